// File: rtl/mouse_pkg.sv
// Mouse cursor controller types and cursor bitmap geometry.
package mouse_pkg;
  localparam int CURSOR_W = 16;
  localparam int CURSOR_H = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLAMP  = 2'd1,
    COMMIT = 2'd2
  } mouse_ctl_state_t;
endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants shared across the video pipeline (800x600 @ 40 MHz).
package vga_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: one-cycle pulse on the cycle sig first reads high.
module edge_rise_det (
  input  logic clk40MHz,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic sig_d;

  // delayed copy of the input for edge comparison
  always_ff @(posedge clk40MHz) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
endmodule

// File: rtl/mouse_pos_ctl.sv
// Frame-synchronous cursor position controller: captures decoder updates,
// commits clamped coordinates at vblank rise, hides cursor after idle frames.
module mouse_pos_ctl
  import mouse_pkg::*;
#(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int HIDE_FRAMES = 300
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        pos_valid,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        cursor_en,
  output logic        commit
);
  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - CURSOR_W);
  localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - CURSOR_H);
  localparam logic [11:0] X_RST  = 12'(H_ACTIVE / 2);
  localparam logic [11:0] Y_RST  = 12'(V_ACTIVE / 2);
  localparam int          IDLE_W = (HIDE_FRAMES > 0) ? $clog2(HIDE_FRAMES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HIDE_FRAMES);
  localparam logic        NEVER_HIDE = (HIDE_FRAMES == 0);

  mouse_ctl_state_t state, state_nxt;
  logic              vblnk_rise;
  logic              pending;
  logic [11:0]       pend_x, pend_y;
  logic [11:0]       work_x, work_y;
  logic [IDLE_W-1:0] idle_cnt;
  logic              start;

  edge_rise_det u_vblnk_rise (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .sig      (vblnk),
    .rise     (vblnk_rise)
  );

  // a commit sequence only begins from IDLE; rises in other states are dropped
  assign start = (state == IDLE) && vblnk_rise && pending;

  // state register
  always_ff @(posedge clk40MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: IDLE -> CLAMP -> COMMIT -> IDLE, one step per cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLAMP;
      CLAMP:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // capture latest decoder position; a strobe on the start cycle survives for next frame
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      pending <= 1'b0;
      pend_x  <= '0;
      pend_y  <= '0;
    end else if (pos_valid) begin
      pending <= 1'b1;
      pend_x  <= xpos_raw;
      pend_y  <= ypos_raw;
    end else if (start) begin
      pending <= 1'b0;
    end
  end

  // work registers: snapshot at start, clamp in place during CLAMP
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      work_x <= '0;
      work_y <= '0;
    end else if (start) begin
      work_x <= pend_x;
      work_y <= pend_y;
    end else if (state == CLAMP) begin
      work_x <= (work_x > X_MAX) ? X_MAX : work_x;
      work_y <= (work_y > Y_MAX) ? Y_MAX : work_y;
    end
  end

  // committed outputs, commit strobe and idle-frame tracking
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      xpos      <= X_RST;
      ypos      <= Y_RST;
      commit    <= 1'b0;
      idle_cnt  <= '0;
      cursor_en <= 1'b1;
    end else begin
      commit    <= 1'b0;
      cursor_en <= NEVER_HIDE || (idle_cnt < IDLE_MAX);
      if (state == COMMIT) begin
        xpos     <= work_x;
        ypos     <= work_y;
        commit   <= 1'b1;
        idle_cnt <= '0;
      end else if (state == IDLE && vblnk_rise && !pending && idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Randomized self-checking bench for mouse_pos_ctl against a frame-level model.
module tb_mouse_pos_ctl;
  localparam int HIDE = 3;
  localparam int XMAX = 784;
  localparam int YMAX = 584;

  logic        clk40MHz = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_raw = '0, ypos_raw = '0;
  logic        pos_valid = 1'b0, vblnk = 1'b0;
  logic [11:0] xpos, ypos;
  logic        cursor_en, commit;

  int checks = 0;
  int errors = 0;

  // frame-level reference state
  int  m_x, m_y, m_px, m_py, m_idle;
  bit  m_pend;

  mouse_pos_ctl #(.HIDE_FRAMES(HIDE)) dut (
    .clk40MHz  (clk40MHz),
    .rst       (rst),
    .xpos_raw  (xpos_raw),
    .ypos_raw  (ypos_raw),
    .pos_valid (pos_valid),
    .vblnk     (vblnk),
    .xpos      (xpos),
    .ypos      (ypos),
    .cursor_en (cursor_en),
    .commit    (commit)
  );

  always #12.5 clk40MHz = ~clk40MHz;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_x = 400; m_y = 300; m_pend = 0; m_px = 0; m_py = 0; m_idle = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk40MHz);
    rst = 1'b1; pos_valid = 1'b0; vblnk = 1'b0;
    repeat (cycles) @(negedge clk40MHz);
    rst = 1'b0;
    model_reset();
    chk("rst_xpos", xpos, 400);
    chk("rst_ypos", ypos, 300);
    chk("rst_en", cursor_en, 1);
    chk("rst_commit", commit, 0);
  endtask

  // one frame: strobes during active video, optional strobe coincident with vblank rise
  task automatic run_frame(input int xs[$], input int ys[$], input bit coinc,
                           input int cx, input int cy);
    bit do_commit;
    int ex, ey;
    vblnk = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk40MHz);
      if (i % 2 == 0 && i / 2 < xs.size()) begin
        pos_valid = 1'b1; xpos_raw = 12'(xs[i/2]); ypos_raw = 12'(ys[i/2]);
        m_pend = 1; m_px = xs[i/2]; m_py = ys[i/2];
      end else begin
        pos_valid = 1'b0;
      end
      if (i == 15) begin
        chk("mid_xpos", xpos, m_x);
        chk("mid_commit", commit, 0);
      end
    end
    @(negedge clk40MHz);
    vblnk = 1'b1;
    pos_valid = coinc;
    if (coinc) begin xpos_raw = 12'(cx); ypos_raw = 12'(cy); end
    do_commit = m_pend;
    ex = min_i(m_px, XMAX);
    ey = min_i(m_py, YMAX);
    if (do_commit) m_idle = 0;
    else           m_idle = min_i(m_idle + 1, HIDE);
    m_pend = coinc ? 1'b1 : 1'b0;
    if (coinc) begin m_px = cx; m_py = cy; end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk40MHz);
      pos_valid = 1'b0;
      if (j <= 4) begin
        if (j == 3 && do_commit) begin
          chk("commit_pulse", commit, 1);
          chk("commit_x", xpos, ex);
          chk("commit_y", ypos, ey);
          m_x = ex; m_y = ey;
        end else begin
          chk("commit_idle", commit, 0);
          if (j < 3) chk("hold_x", xpos, m_x);
        end
      end
      if (j == 6) chk("cursor_en", cursor_en, (m_idle < HIDE) ? 1 : 0);
    end
  endtask

  initial begin
    int xs[$], ys[$];
    model_reset();
    do_reset(3);

    // single update
    run_frame('{100}, '{200}, 0, 0, 0);
    chk("t2_x", xpos, 100);
    // latest wins
    run_frame('{10, 20, 30}, '{10, 20, 30}, 0, 0, 0);
    chk("t3_y", ypos, 30);
    // clamp boundaries
    run_frame('{4095}, '{4095}, 0, 0, 0);
    run_frame('{784}, '{584}, 0, 0, 0);
    run_frame('{785}, '{585}, 0, 0, 0);
    // coincident strobe carries over
    run_frame('{50}, '{60}, 1, 70, 80);
    run_frame('{}, '{}, 0, 0, 0);
    chk("t5_x", xpos, 70);
    // idle hide then restore
    run_frame('{}, '{}, 0, 0, 0);
    run_frame('{}, '{}, 0, 0, 0);
    run_frame('{}, '{}, 0, 0, 0);
    chk("t6_hidden", cursor_en, 0);
    run_frame('{5}, '{5}, 0, 0, 0);
    chk("t6_shown", cursor_en, 1);

    // reset mid-operation drops the pending value
    @(negedge clk40MHz);
    pos_valid = 1'b1; xpos_raw = 12'd123; ypos_raw = 12'd45;
    do_reset(1);
    run_frame('{}, '{}, 0, 0, 0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int n;
      bit big, co;
      n   = $urandom_range(0, 4);
      big = $urandom_range(0, 1);
      co  = ($urandom_range(0, 4) == 0);
      xs.delete(); ys.delete();
      for (int k = 0; k < n; k++) begin
        xs.push_back(big ? $urandom_range(0, 4095) : $urandom_range(0, 900));
        ys.push_back(big ? $urandom_range(0, 4095) : $urandom_range(0, 700));
      end
      run_frame(xs, ys, co, $urandom_range(0, 4095), $urandom_range(0, 4095));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
